// File: rtl/mem_bus_if.sv
// Tagged split-transaction bus between a cache/arbiter requester and the memory responder.
interface mem_bus_if;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    modport master (
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag
    );

    modport slave (
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency tagged memory responder over a 64-bit-word array.
// Define MEM_STALL_EN to add LFSR-driven pseudo-random request rejects.
module mem_responder #(
    parameter int MEM_WORDS       = 1024,
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input logic     clock,
    input logic     reset,
    mem_bus_if.slave bus
);
    localparam int         AW        = $clog2(MEM_WORDS);
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic [63:0]   mem [MEM_WORDS];
    logic [AW-1:0] idx;
    logic          is_load, is_store, stall, accept, complete;
    logic [3:0]    next_tag, outstanding;
    logic          unused_addr_bits;

    logic          vld_p  [LATENCY];
    logic [3:0]    tag_p  [LATENCY];
    logic [63:0]   data_p [LATENCY];

    assign idx              = bus.proc2mem_addr[3 +: AW];
    assign unused_addr_bits = ^{bus.proc2mem_addr[31:3+AW], bus.proc2mem_addr[2:0]};
    assign is_load          = (bus.proc2mem_command == BUS_LOAD);
    assign is_store         = (bus.proc2mem_command == BUS_STORE);

`ifdef MEM_STALL_EN
    logic [3:0] lfsr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr <= 4'b1001;
        else       lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    // A slot freed by this cycle's completion only becomes usable next cycle.
    assign accept   = (is_load || is_store) && !reset && !stall &&
                      (outstanding < 4'(MAX_OUTSTANDING));
    assign complete = vld_p[LATENCY-1];

    assign bus.mem2proc_response = accept ? next_tag : 4'd0;
    assign bus.mem2proc_tag      = vld_p[LATENCY-1] ? tag_p[LATENCY-1]  : 4'd0;
    assign bus.mem2proc_data     = vld_p[LATENCY-1] ? data_p[LATENCY-1] : 64'h0;

    always_ff @(posedge clock) begin
        if (accept && is_store) mem[idx] <= bus.proc2mem_data;
    end

    // Stage p0 captures the request; the last stage drives the completion outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
            next_tag    <= 4'd1;
            outstanding <= 4'd0;
        end else begin
            vld_p[0] <= accept;
            for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
            if (accept) next_tag <= (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
            case ({accept, complete})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Load data is read at acceptance so later stores cannot alter it in flight.
    always_ff @(posedge clock) begin
        tag_p[0]  <= next_tag;
        data_p[0] <= is_load ? mem[idx] : 64'h0;
        for (int i = 1; i < LATENCY; i++) begin
            tag_p[i]  <= tag_p[i-1];
            data_p[i] <= data_p[i-1];
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a default instance and a long-latency instance.
module tb_mem_responder;
    localparam int LATA = 4;
    localparam int LATB = 12;
    localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;
    localparam logic [63:0] V1 = 64'h1122334455667788;
    localparam logic [63:0] V2 = 64'hDEADBEEFCAFEF00D;
    localparam logic [63:0] V3 = 64'hA5A5A5A55A5A5A5A;
    localparam logic [63:0] V4 = 64'h0123456789ABCDEF;
    localparam logic [63:0] V5 = 64'h0F0E0D0C0B0A0908;

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] data;
        int          due;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic mon_en = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    mem_bus_if bus_a();
    mem_bus_if bus_b();

    mem_responder #(.MEM_WORDS(1024), .LATENCY(LATA), .MAX_OUTSTANDING(8)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a)
    );
    mem_responder #(.MEM_WORDS(1024), .LATENCY(LATB), .MAX_OUTSTANDING(8)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic drive(input bit sel, input logic [1:0] cmd, input logic [31:0] addr,
                         input logic [63:0] wd);
        if (sel) begin
            bus_b.proc2mem_command = cmd;
            bus_b.proc2mem_addr    = addr;
            bus_b.proc2mem_data    = wd;
        end else begin
            bus_a.proc2mem_command = cmd;
            bus_a.proc2mem_addr    = addr;
            bus_a.proc2mem_data    = wd;
        end
    endtask

    // Issue one request for a cycle; on expected accept, queue the expected completion.
    task automatic req(input bit sel, input logic [1:0] cmd, input logic [31:0] addr,
                       input logic [63:0] wd, input logic [3:0] exp_resp,
                       input logic [63:0] exp_rd);
        exp_t e;
        drive(sel, cmd, addr, wd);
        @(negedge clock);
        if (sel) chk("response_b", 64'(bus_b.mem2proc_response), 64'(exp_resp));
        else     chk("response_a", 64'(bus_a.mem2proc_response), 64'(exp_resp));
        if (exp_resp != 4'd0) begin
            e.tag  = exp_resp;
            e.data = exp_rd;
            e.due  = cyc + (sel ? LATB : LATA);
            if (sel) q_b.push_back(e);
            else     q_a.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, NONE, 32'h0, 64'h0);
        drive(1, NONE, 32'h0, 64'h0);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic mon(input bit sel, input logic [3:0] tag, input logic [63:0] data);
        exp_t e;
        int   qs;
        qs = sel ? q_b.size() : q_a.size();
        if (tag == 4'd0) begin
            chk(sel ? "idle_data_b" : "idle_data_a", data, 64'h0);
        end else if (qs == 0) begin
            chk(sel ? "unexpected_tag_b" : "unexpected_tag_a", 64'(tag), 64'h0);
        end else begin
            if (sel) e = q_b.pop_front();
            else     e = q_a.pop_front();
            chk(sel ? "cpl_tag_b" : "cpl_tag_a", 64'(tag), 64'(e.tag));
            chk(sel ? "cpl_data_b" : "cpl_data_a", data, e.data);
            chk(sel ? "cpl_cycle_b" : "cpl_cycle_a", 64'(cyc), 64'(e.due));
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            mon(0, bus_a.mem2proc_tag, bus_a.mem2proc_data);
            mon(1, bus_b.mem2proc_tag, bus_b.mem2proc_data);
        end
    end

    function automatic logic [3:0] exp_b(input int k);
        if (k <= 7)  return 4'(k + 1);
        if (k <= 12) return 4'd0;
        return 4'(k - 4);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, LOAD, 32'h100, 64'h0);
        drive(1, NONE, 32'h0, 64'h0);
        repeat (2) @(posedge clock);
        #1;
        chk("reset_response", 64'(bus_a.mem2proc_response), 64'h0);
        chk("reset_tag", 64'(bus_a.mem2proc_tag), 64'h0);
        chk("reset_data", bus_a.mem2proc_data, 64'h0);
        drive(0, NONE, 32'h0, 64'h0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Store then load through the default instance
        req(0, STORE, 32'h100, V1, 4'd1, 64'h0);
        req(0, LOAD,  32'h100, 64'h0, 4'd2, V1);
        idle(6);

        // Reset pulse, then streaming loads; the stored word must survive reset
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) req(0, LOAD, 32'h100, 64'h0, 4'(k + 1), V1);

        // Tag wrap 15->1 and address aliasing modulo the array size
        req(0, STORE, 32'h2000, V2, 4'd11, 64'h0);
        req(0, LOAD,  32'h0,    64'h0, 4'd12, V2);
        req(0, LOAD,  32'h5,    64'h0, 4'd13, V2);
        req(0, LOAD,  32'h100,  64'h0, 4'd14, V1);
        req(0, STORE, 32'h108,  V3, 4'd15, 64'h0);
        req(0, LOAD,  32'h108,  64'h0, 4'd1, V3);
        req(0, LOAD,  32'h2108, 64'h0, 4'd2, V3);
        req(0, 2'd3,  32'h108,  64'h0, 4'd0, 64'h0);

        // In-flight load keeps its data across a later store to the same word
        req(0, LOAD,  32'h108, 64'h0, 4'd3, V3);
        req(0, STORE, 32'h108, V4, 4'd4, 64'h0);
        req(0, LOAD,  32'h108, 64'h0, 4'd5, V4);
        for (int k = 0; k < 3; k++) req(0, LOAD, 32'h100, 64'h0, 4'(6 + k), V1);

        // Reset with loads outstanding: outputs clear at once, nothing completes
        reset = 1'b1;
        q_a.delete();
        q_b.delete();
        #1;
        chk("midreset_tag", 64'(bus_a.mem2proc_tag), 64'h0);
        chk("midreset_data", bus_a.mem2proc_data, 64'h0);
        drive(0, LOAD, 32'h108, 64'h0);
        @(negedge clock);
        chk("midreset_response", 64'(bus_a.mem2proc_response), 64'h0);
        @(posedge clock);
        #1;
        drive(0, NONE, 32'h0, 64'h0);
        reset = 1'b0;
        idle(16);
        req(0, LOAD, 32'h108, 64'h0, 4'd1, V4);
        idle(8);

        // Back-pressure on the long-latency instance with a held command
        for (int k = 0; k < 16; k++) begin
            if (k == 0) req(1, STORE, 32'h40, V5, 4'd1, 64'h0);
            else        req(1, LOAD,  32'h40, 64'h0, exp_b(k), V5);
        end
        idle(20);

        chk("drain_a", 64'(q_a.size()), 64'h0);
        chk("drain_b", 64'(q_b.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
